// File: rtl/adder_window_avg.sv
// Window averager behind the adder: sums 2^LOG2W accepted samples and emits their mean over valid/ready.
// Define ADDER_WINDOW_AVG_ROUND_EN for round-half-up means; the default build truncates.
module adder_window_avg #(
  parameter int N     = 16,
  parameter int LOG2W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] _in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [N-1:0] _out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int AW = N + LOG2W;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state;
  logic [AW-1:0]      acc;
  logic [LOG2W-1:0]   cnt;
  logic               last;
  logic               accept;
  logic               close;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      sum_r;

  assign last      = &cnt;
  assign out_valid = (state == FULL);
  // Stall only when the closing sample would overwrite a result nobody has taken.
  assign in_ready  = !(out_valid && !out_ready && last);
  assign accept    = in_valid && in_ready && !flush;
  assign close     = accept && last;
  assign sum       = acc + AW'(_in);

`ifdef ADDER_WINDOW_AVG_ROUND_EN
  // Half-LSB bias cannot carry out of AW bits since W*(2^N-1) + W/2 < W*2^N.
  assign sum_r = sum + AW'(1 << (LOG2W - 1));
`else
  assign sum_r = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      _out  <= '0;
      state <= EMPTY;
    end else begin
      if (flush) begin
        acc <= '0;
        cnt <= '0;
      end else if (close) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end

      if (close)
        _out <= sum_r[AW-1:LOG2W];

      case (state)
        EMPTY: if (close) state <= FULL;
        FULL:  if (out_ready && !close) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_window_avg.sv
// Directed bench for adder_window_avg: the driver queues hand-computed means, a negedge monitor checks each transfer.
module tb_adder_window_avg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] _in;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] _out;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

`ifdef ADDER_WINDOW_AVG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  adder_window_avg #(.N(16), .LOG2W(3)) dut (
    .clk(clk), .rst(rst), ._in(_in), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), ._out(_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid&&ready at the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out actual=%0h required=none", _out);
      end else begin
        chk("mean", {16'h0, _out}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [15:0] v);
    int t = 0;
    _in = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; _in = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out", {16'h0, _out}, 32'd0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Basic window 1..8: sum 36
    exp_q.push_back(RND ? 16'd5 : 16'd4);
    for (int i = 1; i <= 8; i++) begin
      send(16'(i));
      chk("basic_in_ready", {31'h0, in_ready}, 32'd1);
    end
    idle(2);

    // Full scale: no wrap in either build
    exp_q.push_back(16'hFFFF);
    for (int i = 0; i < 8; i++) send(16'hFFFF);
    idle(2);

    // Backpressure across two windows of 10
    out_ready = 1'b0;
    exp_q.push_back(16'd10);
    for (int i = 0; i < 8; i++) send(16'd10);
    chk("bp_valid_first", {31'h0, out_valid}, 32'd1);
    for (int i = 0; i < 7; i++) send(16'd10);
    exp_q.push_back(16'd10);
    _in = 16'd10;
    in_valid = 1'b1;
    #1;
    chk("bp_stall", {31'h0, in_ready}, 32'd0);
    chk("bp_hold_out", {16'h0, _out}, 32'd10);
    idle(3);
    chk("bp_stall_late", {31'h0, in_ready}, 32'd0);
    chk("bp_hold_valid", {31'h0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_replace_valid", {31'h0, out_valid}, 32'd1);
    chk("bp_replace_out", {16'h0, _out}, 32'd10);
    idle(1);
    chk("bp_drained", {31'h0, out_valid}, 32'd0);
    idle(1);

    // Gapped input: 24 >> 3 = 3, round gives (24+4)>>3 = 3
    exp_q.push_back(16'd3);
    send(16'd8); idle(2);
    for (int i = 0; i < 6; i++) begin send(16'd0); idle(i % 3); end
    idle(3);
    send(16'd16);
    idle(2);

    // Flush drops partial window and the same-cycle sample
    for (int i = 0; i < 5; i++) send(16'd100);
    _in = 16'd100; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_no_close", {31'h0, out_valid}, 32'd0);
    exp_q.push_back(16'd2);
    for (int i = 0; i < 8; i++) send(16'd2);
    idle(2);

    // Async reset with a pending result and cnt=5
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'd3);
    for (int i = 0; i < 5; i++) send(16'd3);
    chk("pre_rst_valid", {31'h0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'h0, out_valid}, 32'd0);
    chk("async_rst_out", {16'h0, _out}, 32'd0);
    chk("async_rst_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(16'd7);
    for (int i = 0; i < 8; i++) send(16'd7);
    idle(3);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
